// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction ROM loader.
//   - instruction / address bus widths of the openmips fetch port
//   - default image header width
//   - NOP word returned for disabled or out-of-range fetches
//   - loader FSM state encoding
package inst_rom_loader_pkg;

   localparam int INST_W     = 32;
   localparam int ADDR_BUS_W = 32;
   localparam int HDR_CNT_W  = 16;

   localparam logic [INST_W-1:0] NOP_INST = 32'h0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LOAD = 3'd2,
      ST_DONE = 3'd3,
      ST_RUN  = 3'd4
   } ld_state_t;

endpackage

// File: rtl/inst_rom_loader_mem.sv
// inst_mem_array: 2**ADDR_W x 32-bit instruction store.
//   clk    : system clock
//   we     : write enable (one word per cycle)
//   waddr  : write word address
//   wdata  : write word
//   raddr  : read word address
//   rdata  : read word, combinational (the core registers it in IF/ID)
// The array is never cleared; contents survive reset.
module inst_mem_array
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [INST_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [INST_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [INST_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction memory for the openmips core with a
// byte-serial image loader.
//   clk        : system clock
//   rst        : synchronous, active-low reset
//   ce_i       : fetch enable from the core
//   addr_i     : byte fetch address from the core PC
//   inst_o     : instruction word (NOP when disabled / out of range)
//   ld_start_i : request a (re)load
//   ld_valid_i : load byte valid
//   ld_data_i  : load byte
//   ld_ready_o : load byte ready (HDR and LOAD only)
//   ld_done_o  : image loaded, core running
//   ld_err_o   : image overflowed memory, sticky until next load
//   core_rst_o : active-high reset to the core, released in RUN
// Image format: 2-byte big-endian word count N, then 4N big-endian bytes.
module inst_rom_loader
   import inst_rom_loader_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = HDR_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce_i,
   input  logic [ADDR_BUS_W-1:0] addr_i,
   output logic [INST_W-1:0]     inst_o,
   input  logic                  ld_start_i,
   input  logic                  ld_valid_i,
   input  logic [7:0]            ld_data_i,
   output logic                  ld_ready_o,
   output logic                  ld_done_o,
   output logic                  ld_err_o,
   output logic                  core_rst_o
);

   ld_state_t state_reg, state_next;

   // One extra pointer bit: it becomes 1 exactly when memory is full,
   // which is where the pointer saturates.
   logic [ADDR_W:0]   ptr_reg;
   logic [1:0]        byte_cnt_reg;
   logic [CNT_W-1:0]  count_reg;    // words still to receive
   logic [23:0]       shift_reg;    // first three bytes of the word in flight
   logic              ready_reg;
   logic              done_reg;
   logic              err_reg;
   logic              core_rst_reg;

   logic              accept;
   logic              hdr_last;
   logic              word_last;
   logic              img_last;
   logic              mem_full;
   logic              mem_we;
   logic [CNT_W-1:0]  hdr_count;
   logic [INST_W-1:0] mem_wdata;
   logic [INST_W-1:0] mem_rdata;
   logic              in_range;
   logic              unused_addr_lsb;

   assign accept    = ld_valid_i & ready_reg;
   assign hdr_last  = accept && (state_reg == ST_HDR)  && (byte_cnt_reg == 2'd1);
   assign word_last = accept && (state_reg == ST_LOAD) && (byte_cnt_reg == 2'd3);
   assign img_last  = word_last && (count_reg == CNT_W'(1));
   // Header byte 0 sits in the low byte of the shift register.
   assign hdr_count = CNT_W'({shift_reg[7:0], ld_data_i});
   assign mem_full  = ptr_reg[ADDR_W];
   assign mem_we    = word_last & ~mem_full;
   assign mem_wdata = {shift_reg, ld_data_i};

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (ld_start_i) state_next = ST_HDR;
         ST_HDR:  if (hdr_last)   state_next = (hdr_count == '0) ? ST_DONE : ST_LOAD;
         ST_LOAD: if (img_last)   state_next = ST_DONE;
         ST_DONE:                 state_next = ST_RUN;
         ST_RUN:  if (ld_start_i) state_next = ST_HDR;
         default:                 state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= '0;
         byte_cnt_reg <= '0;
         count_reg    <= '0;
         shift_reg    <= '0;
         ready_reg    <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         core_rst_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         // Outputs decode the state being entered so they line up with it.
         ready_reg    <= (state_next == ST_HDR) || (state_next == ST_LOAD);
         done_reg     <= (state_next == ST_RUN);
         core_rst_reg <= (state_next != ST_RUN);

         if ((state_next == ST_HDR) && (state_reg != ST_HDR)) begin
            ptr_reg      <= '0;
            byte_cnt_reg <= '0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
         end else if (accept) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            shift_reg    <= {shift_reg[15:0], ld_data_i};
            if (hdr_last) begin
               count_reg    <= hdr_count;
               byte_cnt_reg <= '0;
            end
            if (word_last) begin
               count_reg <= count_reg - CNT_W'(1);
               if (mem_full) begin
                  err_reg <= 1'b1;
               end else begin
                  ptr_reg <= ptr_reg + 1'b1;
               end
            end
         end
      end
   end

   inst_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (ptr_reg[ADDR_W-1:0]),
      .wdata (mem_wdata),
      .raddr (addr_i[ADDR_W+1:2]),
      .rdata (mem_rdata)
   );

   // Any set bit above the memory window is an out-of-range fetch.
   assign in_range        = (addr_i[ADDR_BUS_W-1:ADDR_W+2] == '0);
   assign inst_o          = (ce_i && in_range) ? mem_rdata : NOP_INST;
   assign unused_addr_lsb = ^addr_i[1:0];

   assign ld_ready_o = ready_reg;
   assign ld_done_o  = done_reg;
   assign ld_err_o   = err_reg;
   assign core_rst_o = core_rst_reg;

endmodule
